ripemd160_combine: RTL and testbench

Final-combination stage of the RIPEMD-160 unit in the Hash160 datapath. It sits directly downstream of the left-line and right-line compression cores. It captures each line's 160-bit {A,B,C,D,E} result and adds both results to the chaining value. It then presents the byte-ordered 160-bit digest on a valid/ready output.

---
 rtl/ripemd160_pkg.sv | 42 ++++
 rtl/ripemd160_edge_capture.sv | 49 ++++
 rtl/ripemd160_combine.sv | 147 ++++++++++++++
 tb/tb_ripemd160_combine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ripemd160_pkg.sv
// Shared RIPEMD-160 types, IV constants and word helpers.
// Used by ripemd160_combine and ripemd160_edge_capture.
package ripemd160_pkg;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;

    typedef logic [159:0] rmd_res_t;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_OUT  = 1'b1
    } rmd_state_t;

    function automatic logic [31:0] get_a(input rmd_res_t x);
        return x[159:128];
    endfunction

    function automatic logic [31:0] get_b(input rmd_res_t x);
        return x[127:96];
    endfunction

    function automatic logic [31:0] get_c(input rmd_res_t x);
        return x[95:64];
    endfunction

    function automatic logic [31:0] get_d(input rmd_res_t x);
        return x[63:32];
    endfunction

    function automatic logic [31:0] get_e(input rmd_res_t x);
        return x[31:0];
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_edge_capture.sv
// Rising-edge capture of one compression line's result,
// with a pending flag and sticky overflow on a double capture.
module ripemd160_edge_capture
    import ripemd160_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_valid,
    input  rmd_res_t i_data,
    input  logic     i_clr,
    output logic     o_cap,
    output logic     o_flag,
    output rmd_res_t o_data,
    output logic     o_err
);

    logic     r_prev;
    logic     r_flag;
    logic     r_err;
    rmd_res_t r_data;
    logic     w_edge;

    assign w_edge = i_valid & ~r_prev;
    assign o_cap  = w_edge & ~r_flag;
    assign o_flag = r_flag;
    assign o_data = r_data;
    assign o_err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_flag <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else begin
            r_prev <= i_valid;
            if (o_cap)
                r_data <= i_data;
            // A capture consumed in the same cycle as the clear leaves no flag.
            if (i_clr)
                r_flag <= 1'b0;
            else if (o_cap)
                r_flag <= 1'b1;
            if (w_edge & r_flag)
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/ripemd160_combine.sv
// RIPEMD-160 final combine of left/right lines into a byte-swapped digest.
// Define RIPEMD160_COMBINE_CHAIN_EN for multi-block chaining of H.
module ripemd160_combine
    import ripemd160_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           l_valid,
    input  logic [159:0]   l_data,
    input  logic           l_last,
    input  logic           r_valid,
    input  logic [159:0]   r_data,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [159:0]   digest,
    output logic           busy,
    output logic           err
);

    rmd_state_t r_state;
    rmd_state_t w_state_nxt;

    logic     w_l_cap, w_l_flag, w_l_err;
    logic     w_r_cap, w_r_flag, w_r_err;
    rmd_res_t w_l_hold, w_r_hold;
    rmd_res_t w_l, w_r;
    logic     w_go, w_hs;

    logic [31:0] w_hc [5];
    logic [31:0] w_h  [5];
    logic [31:0] r_sum [5];

    ripemd160_edge_capture u_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (l_valid),
        .i_data  (l_data),
        .i_clr   (w_go),
        .o_cap   (w_l_cap),
        .o_flag  (w_l_flag),
        .o_data  (w_l_hold),
        .o_err   (w_l_err)
    );

    ripemd160_edge_capture u_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_valid),
        .i_data  (r_data),
        .i_clr   (w_go),
        .o_cap   (w_r_cap),
        .o_flag  (w_r_flag),
        .o_data  (w_r_hold),
        .o_err   (w_r_err)
    );

    // Same-cycle captures bypass the holding register into the combine.
    assign w_l = w_l_cap ? l_data : w_l_hold;
    assign w_r = w_r_cap ? r_data : w_r_hold;

    assign w_go = (r_state == ST_WAIT)
                & (w_l_flag | w_l_cap)
                & (w_r_flag | w_r_cap);
    assign w_hs = o_valid & o_ready;

    assign w_h[0] = w_hc[1] + get_c(w_l) + get_d(w_r);
    assign w_h[1] = w_hc[2] + get_d(w_l) + get_e(w_r);
    assign w_h[2] = w_hc[3] + get_e(w_l) + get_a(w_r);
    assign w_h[3] = w_hc[4] + get_a(w_l) + get_b(w_r);
    assign w_h[4] = w_hc[0] + get_b(w_l) + get_c(w_r);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_WAIT: if (w_go) w_state_nxt = ST_OUT;
            ST_OUT:  if (w_hs) w_state_nxt = ST_WAIT;
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            for (int i = 0; i < 5; i++)
                r_sum[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_go)
                for (int i = 0; i < 5; i++)
                    r_sum[i] <= w_h[i];
        end
    end

`ifdef RIPEMD160_COMBINE_CHAIN_EN
    logic        r_last_hold;
    logic        r_last_blk;
    logic [31:0] r_hc [5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_hold <= 1'b0;
            r_last_blk  <= 1'b0;
            r_hc[0]     <= IV0;
            r_hc[1]     <= IV1;
            r_hc[2]     <= IV2;
            r_hc[3]     <= IV3;
            r_hc[4]     <= IV4;
        end else begin
            if (w_l_cap)
                r_last_hold <= l_last;
            if (w_go)
                r_last_blk <= w_l_cap ? l_last : r_last_hold;
            if (w_hs) begin
                if (r_last_blk) begin
                    r_hc[0] <= IV0;
                    r_hc[1] <= IV1;
                    r_hc[2] <= IV2;
                    r_hc[3] <= IV3;
                    r_hc[4] <= IV4;
                end else begin
                    for (int i = 0; i < 5; i++)
                        r_hc[i] <= r_sum[i];
                end
            end
        end
    end

    assign w_hc = r_hc;
`else
    logic w_unused_last;
    assign w_unused_last = l_last;

    assign w_hc[0] = IV0;
    assign w_hc[1] = IV1;
    assign w_hc[2] = IV2;
    assign w_hc[3] = IV3;
    assign w_hc[4] = IV4;
`endif

    assign o_valid = (r_state == ST_OUT);
    assign digest  = {bswap32(r_sum[0]), bswap32(r_sum[1]),
                      bswap32(r_sum[2]), bswap32(r_sum[3]),
                      bswap32(r_sum[4])};
    assign busy    = w_l_flag | w_r_flag | o_valid;
    assign err     = w_l_err | w_r_err;

endmodule

// File: tb/tb_ripemd160_combine.sv
// Directed self-checking bench for ripemd160_combine.
// Chaining steps run when RIPEMD160_COMBINE_CHAIN_EN is defined.
module tb_ripemd160_combine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         l_valid, l_last, r_valid, o_ready;
    logic [159:0] l_data, r_data;
    logic         o_valid, busy, err;
    logic [159:0] digest;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [159:0] Z0 =
        160'h89abcdef_fedcba98_76543210_f0e1d2c3_01234567;
    localparam logic [159:0] Z1 =
        160'h89abcdef_fedcba98_76543210_f1e1d2c3_01234567;
    localparam logic [159:0] ZOV =
        160'h89abcdef_fedcba98_76543210_9a8c7d6e_01234567;
    localparam logic [159:0] ZCH =
        160'hfedcba98_76543210_f0e1d2c3_01234567_89abcdef;

    ripemd160_combine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .l_valid (l_valid),
        .l_data  (l_data),
        .l_last  (l_last),
        .r_valid (r_valid),
        .r_data  (r_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .digest  (digest),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        l_valid = 1'b0; r_valid = 1'b0; l_last = 1'b1;
        l_data = '0; r_data = '0; o_ready = 1'b1;
        step(); step();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_digest", digest, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        // zero inputs, same-cycle pulses
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        chk("zero_o_valid", o_valid, 1);
        chk("zero_digest", digest, Z0);
        step();
        chk("zero_hs_o_valid", o_valid, 0);
        chk("zero_hs_busy", busy, 0);

        // skewed capture, left held high
        l_data = {32'h00000001, 128'h0};
        l_valid = 1;
        step();
        chk("skew_busy", busy, 1);
        chk("skew_no_out", o_valid, 0);
        repeat (4) step();
        chk("skew_still_wait", o_valid, 0);
        r_valid = 1;
        step();
        r_valid = 0;
        chk("skew_o_valid", o_valid, 1);
        chk("skew_digest", digest, Z1);
        step();
        chk("skew_hs", o_valid, 0);
        step(); step();
        chk("skew_once_valid", o_valid, 0);
        chk("skew_once_busy", busy, 0);
        l_valid = 0;
        step();

        // backpressure with early capture
        o_ready = 0;
        l_data = '0;
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        chk("bp_o_valid", o_valid, 1);
        chk("bp_digest", digest, Z0);
        step();
        l_data = {32'h00000001, 128'h0};
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        repeat (7) step();
        chk("bp_hold_valid", o_valid, 1);
        chk("bp_hold_digest", digest, Z0);
        chk("bp_no_err", err, 0);
        o_ready = 1;
        step();
        chk("bp_hs", o_valid, 0);
        step();
        chk("bp_second_valid", o_valid, 1);
        chk("bp_second_digest", digest, Z1);
        step();
        chk("bp_second_hs", o_valid, 0);
        chk("bp_idle_busy", busy, 0);

        // overflow: two left pulses
        l_data = {32'haaaaaaaa, 128'h0};
        l_valid = 1;
        step();
        l_valid = 0;
        step();
        chk("ov_no_err_yet", err, 0);
        l_data = {32'h11111111, 128'h0};
        l_valid = 1;
        step();
        l_valid = 0;
        chk("ov_err", err, 1);
        step();
        r_valid = 1;
        step();
        r_valid = 0;
        chk("ov_o_valid", o_valid, 1);
        chk("ov_digest", digest, ZOV);
        step(); step(); step();
        chk("ov_err_sticky", err, 1);

        // reset mid-operation
        rst_n = 0;
        #1;
        chk("mr_err_clr", err, 0);
        step();
        rst_n = 1;
        step();
        l_data = '0;
        l_valid = 1;
        step();
        l_valid = 0;
        chk("mr_left_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("mr_busy_clr", busy, 0);
        step();
        rst_n = 1;
        step();
        r_valid = 1;
        step();
        r_valid = 0;
        chk("mr_right_no_out", o_valid, 0);
        step(); step();
        chk("mr_right_no_out2", o_valid, 0);

`ifdef RIPEMD160_COMBINE_CHAIN_EN
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        l_data = '0; r_data = '0;
        l_last = 0;
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        chk("ch_first", digest, Z0);
        step();
        l_last = 1;
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        chk("ch_second", digest, ZCH);
        step();
        l_valid = 1; r_valid = 1;
        step();
        l_valid = 0; r_valid = 0;
        chk("ch_iv_restored", digest, Z0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
